// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter / fetch sequencer with a run/halt state machine.
//
// Ports:
//   Clk        clock; all state changes on the rising edge
//   Reset      synchronous reset, active-high; beats every other input
//   Start      level-sampled run request (IDLE -> RUN, DONE -> RUN)
//   Halt       halt instruction decoded at the current ProgCtr
//   Stall      fetch/memory not ready; hold the PC
//   BranchEn   current instruction is a conditional relative branch
//   BranchCond branch condition flag from the ALU
//   Target     signed two's-complement PC-relative offset
//   ProgCtr    registered instruction address
//   Running    high while in RUN
//   Done       high in DONE (and FAULT)
//   CycleCnt   saturating count of RUN cycles, stalls and halt included
//   Fault      wrap fault flag
//
// Optional feature: define PC_WRAP_FAULT_EN to turn a PC wrap in RUN into a sticky
// FAULT state. Without it wraps are silent modulo 2^D and Fault is constant 0.

module pc_sequencer #(
  parameter int unsigned D          = 12,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic             BranchCond,
  input  logic [D-1:0]     Target,
  output logic [D-1:0]     ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCnt,
  output logic             Fault
);

  localparam logic [D-1:0] StartPc = D'(START_ADDR);

  // Bit D of the sum is the wrap indicator; it only matters when wrap faults are
  // enabled, so the default build keeps a plain modulo-2^D adder.
`ifdef PC_WRAP_FAULT_EN
  localparam int unsigned SumW = D + 1;
`else
  localparam int unsigned SumW = D;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone, StFault} state_e;

  state_e           state_q, state_d;
  logic [D-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             taken;
  logic [SumW-1:0]  pc_ext, off_ext, step_sum;
  logic [CNT_W-1:0] cnt_inc;

  // Next-PC adder: offset is sign-extended, increment is zero-extended.
  always_comb begin
    taken    = BranchEn & BranchCond;
    pc_ext   = SumW'(pc_q);
    off_ext  = taken ? SumW'($signed(Target)) : SumW'(1);
    step_sum = pc_ext + off_ext;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // State register and datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      pc_q    <= StartPc;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_inc;
        if (Halt) begin
          state_d = StDone;
        end else if (!Stall) begin
`ifdef PC_WRAP_FAULT_EN
          if (step_sum[D]) begin
            state_d = StFault;
          end else begin
            pc_d = step_sum[D-1:0];
          end
`else
          pc_d = step_sum[D-1:0];
`endif
        end
      end
      StDone: begin
        if (Start) begin
          state_d = StRun;
          pc_d    = StartPc;
          cnt_d   = '0;
        end
      end
      StFault: begin
        // Sticky until Reset
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    Running = (state_q == StRun);
    Done    = (state_q == StDone) || (state_q == StFault);
`ifdef PC_WRAP_FAULT_EN
    Fault   = (state_q == StFault);
`else
    Fault   = 1'b0;
`endif
  end

  assign ProgCtr  = pc_q;
  assign CycleCnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven bench for pc_sequencer, plus hand sequences for
// mid-cycle input changes and CycleCnt saturation (on a narrow-counter instance).

module tb_pc_sequencer;

`ifdef PC_WRAP_FAULT_EN
  localparam bit WrapFault = 1'b1;
`else
  localparam bit WrapFault = 1'b0;
`endif

  logic        clk;
  logic        reset, start, halt, stall, branch_en, branch_cond;
  logic [11:0] target;
  logic [11:0] pc_a, pc_b;
  logic        run_a, run_b, done_a, done_b, flt_a, flt_b;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;

  int n_cmp  = 0;
  int n_fail = 0;

  pc_sequencer #(.D(12), .START_ADDR(0), .CNT_W(16)) dut_a (
    .Clk(clk), .Reset(reset), .Start(start), .Halt(halt), .Stall(stall),
    .BranchEn(branch_en), .BranchCond(branch_cond), .Target(target),
    .ProgCtr(pc_a), .Running(run_a), .Done(done_a), .CycleCnt(cnt_a), .Fault(flt_a)
  );

  pc_sequencer #(.D(12), .START_ADDR(0), .CNT_W(3)) dut_b (
    .Clk(clk), .Reset(reset), .Start(start), .Halt(halt), .Stall(stall),
    .BranchEn(branch_en), .BranchCond(branch_cond), .Target(target),
    .ProgCtr(pc_b), .Running(run_b), .Done(done_b), .CycleCnt(cnt_b), .Fault(flt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, st, hl, sl, be, bc;
    logic [11:0] tgt;
    logic [11:0] pc;
    logic        run, done;
    logic [15:0] cnt;
    logic        flt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic rst, logic st, logic hl, logic sl, logic be,
                              logic bc, logic [11:0] tgt, logic [11:0] pc, logic run,
                              logic done, logic [15:0] cnt, logic flt);
    vec_t v;
    v.name = n; v.rst = rst; v.st = st; v.hl = hl; v.sl = sl; v.be = be; v.bc = bc;
    v.tgt = tgt; v.pc = pc; v.run = run; v.done = done; v.cnt = cnt; v.flt = flt;
    vecs.push_back(v);
  endfunction

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic st, logic hl, logic sl, logic be, logic bc,
                       logic [11:0] tgt);
    @(negedge clk);
    reset = rst; start = st; halt = hl; stall = sl;
    branch_en = be; branch_cond = bc; target = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; stall = 1'b0;
    branch_en = 1'b0; branch_cond = 1'b0; target = '0;

    //  name          rst st hl sl be bc tgt       pc      run done cnt flt
    add("reset",       1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0);
    add("idle_hold",   0, 0, 0, 0, 1, 1, 12'h005, 12'h000, 0, 0, 0, 0);
    add("start",       0, 1, 0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0, 0);
    add("inc1",        0, 0, 0, 0, 0, 0, 12'h000, 12'h001, 1, 0, 1, 0);
    add("inc2",        0, 0, 0, 0, 0, 0, 12'h000, 12'h002, 1, 0, 2, 0);
    add("inc3",        0, 0, 0, 0, 0, 0, 12'h000, 12'h003, 1, 0, 3, 0);
    add("br_to10",     0, 0, 0, 0, 1, 1, 12'h007, 12'h00A, 1, 0, 4, 0);
    add("br_back5",    0, 0, 0, 0, 1, 1, 12'hFFB, 12'h005, 1, 0, 5, 0);
    add("br_fwd5",     0, 0, 0, 0, 1, 1, 12'h005, 12'h00A, 1, 0, 6, 0);
    add("br_cond0",    0, 0, 0, 0, 1, 0, 12'hFFB, 12'h00B, 1, 0, 7, 0);
    add("br_en0",      0, 0, 0, 0, 0, 1, 12'hFFB, 12'h00C, 1, 0, 8, 0);
    add("br_back7",    0, 0, 0, 0, 1, 1, 12'hFFB, 12'h007, 1, 0, 9, 0);
    add("br_back2",    0, 0, 0, 0, 1, 1, 12'hFFE, 12'h005, 1, 0, 10, 0);
    add("br_014",      0, 0, 0, 0, 1, 1, 12'h014, 12'h019, 1, 0, 11, 0);
    add("br_spin",     0, 0, 0, 0, 1, 1, 12'h000, 12'h019, 1, 0, 12, 0);
    add("br_to7",      0, 0, 0, 0, 1, 1, 12'hFEE, 12'h007, 1, 0, 13, 0);
    add("stall1",      0, 0, 0, 1, 0, 0, 12'h000, 12'h007, 1, 0, 14, 0);
    add("stall2_br",   0, 0, 0, 1, 1, 1, 12'h010, 12'h007, 1, 0, 15, 0);
    add("stall3",      0, 1, 0, 1, 0, 0, 12'h000, 12'h007, 1, 0, 16, 0);
    add("unstall",     0, 0, 0, 0, 0, 0, 12'h000, 12'h008, 1, 0, 17, 0);
    add("br_to20",     0, 0, 0, 0, 1, 1, 12'h00C, 12'h014, 1, 0, 18, 0);
    add("halt_br",     0, 0, 1, 0, 1, 1, 12'h005, 12'h014, 0, 1, 19, 0);
    add("done_hold",   0, 0, 0, 0, 1, 1, 12'h005, 12'h014, 0, 1, 19, 0);
    add("done_hold2",  0, 0, 1, 1, 0, 0, 12'h000, 12'h014, 0, 1, 19, 0);
    add("restart",     0, 1, 0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0, 0);
    add("run_start",   0, 1, 0, 0, 0, 0, 12'h000, 12'h001, 1, 0, 1, 0);
    add("br_7ff_a",    0, 0, 0, 0, 1, 1, 12'h7FF, 12'h800, 1, 0, 2, 0);
    add("br_7ff_b",    0, 0, 0, 0, 1, 1, 12'h7FF, 12'hFFF, 1, 0, 3, 0);
    if (WrapFault) begin
      add("wrap_inc",  0, 0, 0, 0, 0, 0, 12'h000, 12'hFFF, 0, 1, 4, 1);
      add("flt_start", 0, 1, 0, 0, 0, 0, 12'h000, 12'hFFF, 0, 1, 4, 1);
      add("flt_br",    0, 0, 0, 0, 1, 1, 12'hFFE, 12'hFFF, 0, 1, 4, 1);
    end else begin
      add("wrap_inc",  0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 4, 0);
      add("run_start2",0, 1, 0, 0, 0, 0, 12'h000, 12'h001, 1, 0, 5, 0);
      add("neg_wrap",  0, 0, 0, 0, 1, 1, 12'hFFE, 12'hFFF, 1, 0, 6, 0);
    end
    add("reset2",      1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0);
    add("start2",      0, 1, 0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0, 0);
    add("br_to50",     0, 0, 0, 0, 1, 1, 12'h032, 12'h032, 1, 0, 1, 0);
    add("reset_mid",   1, 1, 1, 1, 1, 1, 12'h005, 12'h000, 0, 0, 0, 0);
    add("idle_after",  0, 0, 1, 1, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0);
    add("start3",      0, 1, 0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0, 0);
    if (WrapFault) begin
      add("neg_fault", 0, 0, 0, 0, 1, 1, 12'hFFF, 12'h000, 0, 1, 1, 1);
      add("flt_halt",  0, 0, 1, 0, 0, 0, 12'h000, 12'h000, 0, 1, 1, 1);
    end else begin
      add("neg_wrap2", 0, 0, 0, 0, 1, 1, 12'hFFF, 12'hFFF, 1, 0, 1, 0);
      add("halt_fff",  0, 0, 1, 0, 0, 0, 12'h000, 12'hFFF, 0, 1, 2, 0);
    end
    add("reset3",      1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].hl, vecs[i].sl, vecs[i].be, vecs[i].bc,
            vecs[i].tgt);
      step();
      check({vecs[i].name, ".pc"},   32'(pc_a),   32'(vecs[i].pc));
      check({vecs[i].name, ".run"},  32'(run_a),  32'(vecs[i].run));
      check({vecs[i].name, ".done"}, 32'(done_a), 32'(vecs[i].done));
      check({vecs[i].name, ".cnt"},  32'(cnt_a),  32'(vecs[i].cnt));
      check({vecs[i].name, ".flt"},  32'(flt_a),  32'(vecs[i].flt));
    end

    // Input changes between edges must not reach ProgCtr.
    drive(0, 1, 0, 0, 0, 0, 12'h000);
    step();
    drive(0, 0, 0, 0, 1, 1, 12'h100);
    #1;
    check("no_comb_path.pc", 32'(pc_a), 32'h000);
    step();
    check("comb_then_edge.pc", 32'(pc_a), 32'h100);

    // Narrow counter saturates at 7 instead of wrapping.
    drive(1, 0, 0, 0, 0, 0, 12'h000);
    step();
    drive(0, 1, 0, 0, 0, 0, 12'h000);
    step();
    check("sat_start.cnt", 32'(cnt_b), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 12'h000);
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("sat_%0d.cnt", k), 32'(cnt_b), (k > 7) ? 32'd7 : 32'(k));
    end
    check("sat_end.pc", 32'(pc_b), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
